// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit shift engine. Serialises one byte (5..8 data
// bits, optional parity, 1 or 2 stop bits) onto txd, pacing each bit with
// OVERSAMPLE ticks of bclk_tx and requesting those ticks via tx_bclk_en.
// Optional feature: define UART_TX_BREAK_EN to add the brk_req line-break input.
module uart_tx_engine #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] cfg_dbits,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic       cfg_stop2,
  input  logic       bclk_tx,
`ifdef UART_TX_BREAK_EN
  input  logic       brk_req,
`endif
  output logic       tx_bclk_en,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [2:0]      last_bit;
  logic [7:0]      shreg;
  logic            par_en_q;
  logic            stop2_q;
  logic            par_bit_q;
  logic            stop_cnt;
`ifdef UART_TX_BREAK_EN
  logic            brk_active;
`endif

  logic [7:0]      data_mask;
  logic            par_calc;
  logic            bit_end;

  // Mask off the unused upper data bits so parity covers only transmitted bits
  always_comb begin
    data_mask = 8'hFF;
    case (cfg_dbits)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  assign par_calc = (^(tx_data & data_mask)) ^ cfg_par_odd;
  assign bit_end  = bclk_tx && (tick_cnt == TICK_LAST);

  // Frame sequencer: tick counting, shifting and all registered outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      txd        <= 1'b1;
      tx_bclk_en <= 1'b0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      last_bit   <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_cnt   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_active <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE && bclk_tx) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg      <= tx_data;
            last_bit   <= {1'b0, cfg_dbits} + 3'd4;
            par_en_q   <= cfg_par_en;
            stop2_q    <= cfg_stop2;
            par_bit_q  <= par_calc;
            state      <= START;
            txd        <= 1'b0;
            tx_bclk_en <= 1'b1;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
          end
`ifdef UART_TX_BREAK_EN
          else if (brk_req) begin
            txd        <= 1'b0;
            tx_ready   <= 1'b0;
            brk_active <= 1'b1;
          end else if (brk_active) begin
            txd        <= 1'b1;
            brk_active <= 1'b0;
          end else begin
            txd      <= 1'b1;
            tx_ready <= 1'b1;
          end
`endif
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == last_bit) begin
              stop_cnt <= 1'b0;
              if (par_en_q) begin
                state <= PARITY;
                txd   <= par_bit_q;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state      <= IDLE;
              tx_bclk_en <= 1'b0;
              tx_done    <= 1'b1;
              tx_ready   <= 1'b1;
              tx_busy    <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed frames with hand-computed txd waveforms for
// uart_tx_engine, covering parity modes, short words, back-to-back transfers,
// mid-frame reset and a slow baud tick with mid-frame cfg changes.
module tb_uart_tx_engine;

  localparam int BUDGET = 1500;

  logic       pclk;
  logic       presetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] cfg_dbits;
  logic       cfg_par_en;
  logic       cfg_par_odd;
  logic       cfg_stop2;
  logic       bclk_tx;
  logic       brk_req;
  logic       tx_bclk_en;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  int checks_total  = 0;
  int checks_passed = 0;
  int tick_period   = 1;
  int tick_div      = 0;

  logic txd_log [0:BUDGET];

  uart_tx_engine #(.OVERSAMPLE(16)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .cfg_dbits   (cfg_dbits),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .bclk_tx     (bclk_tx),
`ifdef UART_TX_BREAK_EN
    .brk_req     (brk_req),
`endif
    .tx_bclk_en  (tx_bclk_en),
    .txd         (txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Baud generator stand-in: tick every cycle, or every tick_period cycles with
  // its divider held at zero while the engine is not requesting ticks
  initial begin
    bclk_tx = 1'b0;
    forever begin
      @(negedge pclk);
      if (tick_period <= 1) begin
        bclk_tx = 1'b1;
      end else if (!tx_bclk_en) begin
        tick_div = 0;
        bclk_tx  = 1'b0;
      end else begin
        tick_div = (tick_div == tick_period - 1) ? 0 : tick_div + 1;
        bclk_tx  = (tick_div == tick_period - 1);
      end
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Called at the first negedge after the accepting posedge; records txd until
  // tx_done and compares every bit window and the frame length
  task automatic captureFrame(input string name, input logic [11:0] exp_bits,
                              input int nbits, input int l0, input int lb,
                              input bit toggle_cfg);
    int done_c;
    int lo;
    int hi;
    int good;
    done_c = 0;
    checkOutput({name, " busy at start"}, int'(tx_busy), 1);
    checkOutput({name, " bclk_en at start"}, int'(tx_bclk_en), 1);
    checkOutput({name, " ready at start"}, int'(tx_ready), 0);
    for (int c = 1; c <= BUDGET; c++) begin
      if (c > 1) @(negedge pclk);
      txd_log[c] = txd;
      if (toggle_cfg && c == 200) begin
        cfg_dbits   = 2'd3;
        cfg_par_en  = 1'b0;
        cfg_par_odd = 1'b0;
        cfg_stop2   = 1'b1;
      end
      if (tx_done) begin
        done_c = c;
        break;
      end
    end
    checkOutput({name, " done cycle"}, done_c, l0 + (nbits - 1) * lb + 1);
    for (int k = 0; k < nbits; k++) begin
      lo   = (k == 0) ? 1 : l0 + (k - 1) * lb + 1;
      hi   = l0 + k * lb;
      good = 0;
      for (int c = lo; c <= hi; c++) begin
        if (c < done_c && c <= BUDGET && txd_log[c] == exp_bits[k]) good++;
      end
      checkOutput($sformatf("%s bit%0d samples", name, k), good, hi - lo + 1);
    end
    checkOutput({name, " ready at done"}, int'(tx_ready), 1);
    checkOutput({name, " bclk_en at done"}, int'(tx_bclk_en), 0);
    checkOutput({name, " txd at done"}, int'(txd), 1);
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] data,
                               input logic [1:0] dbits, input logic par_en,
                               input logic par_odd, input logic stop2,
                               input logic [11:0] exp_bits, input int nbits,
                               input int l0, input int lb, input bit toggle_cfg);
    tx_data     = data;
    cfg_dbits   = dbits;
    cfg_par_en  = par_en;
    cfg_par_odd = par_odd;
    cfg_stop2   = stop2;
    tx_valid    = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    captureFrame(name, exp_bits, nbits, l0, lb, toggle_cfg);
    @(negedge pclk);
    checkOutput({name, " done pulse cleared"}, int'(tx_done), 0);
    checkOutput({name, " busy cleared"}, int'(tx_busy), 0);
  endtask

  initial begin
    int done_seen;
    int low_seen;
    presetn     = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    cfg_dbits   = 2'd3;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;
    brk_req     = 1'b0;

    @(negedge pclk);
    checkOutput("reset txd", int'(txd), 1);
    checkOutput("reset bclk_en", int'(tx_bclk_en), 0);
    checkOutput("reset ready", int'(tx_ready), 1);
    checkOutput("reset busy", int'(tx_busy), 0);
    checkOutput("reset done", int'(tx_done), 0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);

    // Tick tied high: 16 pclk per bit, idle ticks must not be counted
    applyStimulus("8N1 A5", 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 12'h34A, 10, 16, 16, 1'b0);
    applyStimulus("8E1 A5", 8'hA5, 2'd3, 1'b1, 1'b0, 1'b0, 12'h54A, 11, 16, 16, 1'b0);
    applyStimulus("8O1 A5", 8'hA5, 2'd3, 1'b1, 1'b1, 1'b0, 12'h74A, 11, 16, 16, 1'b0);
    applyStimulus("5E2 1F", 8'h1F, 2'd0, 1'b1, 1'b0, 1'b1, 12'h1FE, 9, 16, 16, 1'b0);

    // Back-to-back: tx_valid held, second byte taken on the tx_done cycle
    tx_data     = 8'h55;
    cfg_dbits   = 2'd3;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;
    tx_valid    = 1'b1;
    @(negedge pclk);
    tx_data = 8'h0F;
    captureFrame("b2b 55", 12'h2AA, 10, 16, 16, 1'b0);
    @(negedge pclk);
    tx_valid = 1'b0;
    checkOutput("b2b second start txd", int'(txd), 0);
    captureFrame("b2b 0F", 12'h21E, 10, 16, 16, 1'b0);
    @(negedge pclk);
    checkOutput("b2b no third frame", int'(tx_busy), 0);

    // Reset asserted during data bit 3 of an 8N1 frame
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    repeat (69) @(negedge pclk);
    checkOutput("rst pre txd data bit3", int'(txd), 0);
    checkOutput("rst pre busy", int'(tx_busy), 1);
    presetn = 1'b0;
    #1;
    checkOutput("rst mid txd", int'(txd), 1);
    checkOutput("rst mid bclk_en", int'(tx_bclk_en), 0);
    checkOutput("rst mid busy", int'(tx_busy), 0);
    checkOutput("rst mid ready", int'(tx_ready), 1);
    @(negedge pclk);
    presetn   = 1'b1;
    done_seen = 0;
    low_seen  = 0;
    repeat (200) begin
      @(negedge pclk);
      if (tx_done) done_seen++;
      if (!txd) low_seen++;
    end
    checkOutput("rst no done pulse", done_seen, 0);
    checkOutput("rst line stays idle", low_seen, 0);

    // Slow tick every 5 pclk: 80 pclk per bit (first tick 4 cycles after start)
    tick_period = 5;
    @(negedge pclk);
    applyStimulus("7O1 C6 slow", 8'hC6, 2'd2, 1'b1, 1'b1, 1'b0, 12'h28C, 10, 79, 80, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
